// File: rtl/fifo_burst_reader_if.sv
// Reader bus: FIFO pop side plus the valid/ready output stream, grouped for one port.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_almost_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        input  fifo_empty, fifo_almost_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_almost_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst drainer for the async FIFO read side: pops in bursts (1-cycle data latency) into a 2-entry buffer
// feeding a valid/ready stream; pops only when the buffer has room, so m_ready backpressure stalls the FIFO.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int TIMEOUT    = 32
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    fifo_burst_reader_if.master  bus,
    input  logic                 wc_load_i,
    input  logic [15:0]          wc_load_val_i,
    output logic                 busy,
    output logic [15:0]          word_count
);
    localparam int IW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] ISSUED_MAX = IW'(BURST_LEN);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    // rel=0 marks the burst's youngest word whose m_last value is not yet decided.
    typedef struct packed {
        logic                  rel;
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } ent_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] issued_q, issued_d;
    logic          inflight_q;
    ent_t          e0_q, e0_d, e1_q, e1_d;
    ent_t          new_ent;
    logic [1:0]    cnt_q, cnt_d;
    logic [15:0]   wc_q, wc_d;

    logic          m_valid_w;
    logic          out_pop;
    logic          fifo_pop;
    logic          burst_exit;
    logic [2:0]    occ;

    assign m_valid_w   = (cnt_q != 2'd0) && e0_q.rel;
    assign out_pop     = m_valid_w && bus.m_ready;
    assign bus.m_valid = m_valid_w;
    assign bus.m_data  = e0_q.dat;
    assign bus.m_last  = m_valid_w && e0_q.last;

    // Occupancy after this edge if we do not pop: buffered + in flight - leaving downstream.
    assign occ      = 3'(cnt_q) + 3'(inflight_q) - 3'(out_pop);
    assign fifo_pop = (state_q == BURST) && !bus.fifo_empty
                      && (issued_q < ISSUED_MAX) && (occ < 3'd2);
    assign bus.fifo_rd_en = fifo_pop;

    assign busy       = (state_q != IDLE) || (cnt_q != 2'd0);
    assign word_count = wc_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        issued_d   = issued_q;
        burst_exit = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!bus.fifo_empty) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (!bus.fifo_almost_empty || (timer_q == TIMER_LAST)) begin
                    state_d  = BURST;
                    issued_d = '0;
                end
            end
            BURST: begin
                if (fifo_pop) begin
                    issued_d = issued_q + IW'(1);
                end
                if ((issued_q == ISSUED_MAX) || (bus.fifo_empty && !fifo_pop)) begin
                    state_d    = IDLE;
                    burst_exit = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        e0_d        = e0_q;
        e1_d        = e1_q;
        cnt_d       = cnt_q;
        new_ent.rel  = fifo_pop || burst_exit;
        new_ent.last = burst_exit;
        new_ent.dat  = bus.fifo_data;
        // A later pop or the end of the burst settles the held tail's m_last.
        if (fifo_pop || burst_exit) begin
            if ((cnt_q != 2'd0) && !e0_d.rel) begin
                e0_d.rel  = 1'b1;
                e0_d.last = burst_exit;
            end
            if ((cnt_q == 2'd2) && !e1_d.rel) begin
                e1_d.rel  = 1'b1;
                e1_d.last = burst_exit;
            end
        end
        if (out_pop) begin
            e0_d  = e1_d;
            e1_d  = '0;
            cnt_d = cnt_d - 2'd1;
        end
        if (inflight_q) begin
            if (cnt_d == 2'd0) begin
                e0_d = new_ent;
            end else begin
                e1_d = new_ent;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_comb begin
        wc_d = wc_q;
        if (wc_load_i) begin
            wc_d = wc_load_val_i;
        end else if (out_pop) begin
            wc_d = wc_q + 16'd1;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            e0_q       <= '0;
            e1_q       <= '0;
            cnt_q      <= 2'd0;
            wc_q       <= 16'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            issued_q   <= issued_d;
            inflight_q <= fifo_pop;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            cnt_q      <= cnt_d;
            wc_q       <= wc_d;
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO model on the read side, scoreboard of expected beats.
module tb_fifo_burst_reader;
    localparam int DW       = 8;
    localparam int BL       = 16;
    localparam int TO       = 32;
    localparam int AE_LEVEL = 4;

    logic        rd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        wc_load_i = 1'b0;
    logic [15:0] wc_load_val_i = 16'd0;
    logic        busy;
    logic [15:0] word_count;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .rd_clk        (rd_clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .wc_load_i     (wc_load_i),
        .wc_load_val_i (wc_load_val_i),
        .busy          (busy),
        .word_count    (word_count)
    );

    always #5 rd_clk = ~rd_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int popped = 0;
    int accepted = 0;
    logic [DW-1:0] fq[$];
    logic [DW:0]   exp_q[$];

    logic          o_vld, o_beat, o_last, o_rd_en, o_empty, o_busy, o_rdy;
    logic [DW-1:0] o_dat;
    logic [15:0]   o_wc;

    task automatic set_flags();
        bus.fifo_empty        = (fq.size() == 0);
        bus.fifo_almost_empty = (fq.size() <= AE_LEVEL);
    endtask

    task automatic push_word(input logic [DW-1:0] w, input logic last);
        fq.push_back(w);
        exp_q.push_back({last, w});
        set_flags();
    endtask

    // One clock: sample outputs at negedge, then model the FIFO pop just after posedge.
    task automatic step();
        logic pop_now;
        @(negedge rd_clk);
        o_vld   = bus.m_valid;
        o_rdy   = bus.m_ready;
        o_beat  = bus.m_valid && bus.m_ready;
        o_dat   = bus.m_data;
        o_last  = bus.m_last;
        o_rd_en = bus.fifo_rd_en;
        o_empty = bus.fifo_empty;
        o_busy  = busy;
        o_wc    = word_count;
        pop_now = bus.fifo_rd_en && !bus.fifo_empty;
        @(posedge rd_clk);
        #1;
        if (pop_now) begin
            bus.fifo_data = fq.pop_front();
            popped++;
        end
        if (o_beat) accepted++;
        set_flags();
    endtask

    task automatic test_reset();
        logic [DW+19:0] got;
        bool_wait: begin end
        bus.m_ready   = 1'b1;
        bus.fifo_data = '0;
        set_flags();
        #2;
        got = {bus.fifo_rd_en, bus.m_valid, bus.m_last, busy, word_count, bus.m_data};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_initial outputs=%h required=0", got);
        end
        @(posedge rd_clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) fq.push_back(DW'(8'h50 + i));
        set_flags();
        for (int k = 0; k < 100 && accepted < 3; k++) step();
        n_cmp++;
        if (accepted < 3) begin
            n_bad++;
            $display("FAIL reset_preburst accepted=%0d required>=3", accepted);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.fifo_rd_en, bus.m_valid, bus.m_last, busy, word_count, bus.m_data};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_midburst outputs=%h required=0", got);
        end
        fq.delete();
        exp_q.delete();
        set_flags();
        step();
        step();
        rst_n    = 1'b1;
        popped   = 0;
        accepted = 0;
        step();
        step();
        n_cmp++;
        if ({o_busy, o_rd_en, o_vld, o_wc} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle busy=%b rd_en=%b valid=%b wc=%0d required all 0",
                     o_busy, o_rd_en, o_vld, o_wc);
        end
    endtask

    task automatic test_full_burst();
        logic [DW:0] e;
        bit done = 0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 40; i++) push_word(DW'(i), (i == 15) || (i == 31) || (i == 39));
        for (int k = 0; k < 2000 && !done; k++) begin
            step();
            if (o_beat) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL full_burst unexpected beat data=%h last=%b required none", o_dat, o_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_last, o_dat} !== e) begin
                        n_bad++;
                        $display("FAIL full_burst beat last/data=%b/%h required %b/%h",
                                 o_last, o_dat, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (exp_q.size() == 0 && !o_busy && fq.size() == 0) done = 1;
        end
        n_cmp++;
        if (!done || o_wc !== 16'd40) begin
            n_bad++;
            $display("FAIL full_burst drain done=%b word_count=%0d required done word_count=40", done, o_wc);
        end
    endtask

    task automatic test_timeout();
        logic [DW:0] e;
        int n = 0;
        bit done = 0;
        bus.m_ready = 1'b1;
        push_word(8'hA0, 1'b0);
        push_word(8'hA1, 1'b0);
        push_word(8'hA2, 1'b1);
        step();
        do begin
            step();
            n++;
        end while (!o_rd_en && n < 200);
        n_cmp++;
        if (n - 1 != TO) begin
            n_bad++;
            $display("FAIL timeout_latency first rd_en after %0d cycles required %0d", n - 1, TO);
        end
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            if (o_beat) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL timeout unexpected beat data=%h required none", o_dat);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_last, o_dat} !== e) begin
                        n_bad++;
                        $display("FAIL timeout beat last/data=%b/%h required %b/%h",
                                 o_last, o_dat, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (exp_q.size() == 0 && !o_busy) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout_drain pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [DW:0] e;
        logic          p_stall = 1'b0;
        logic [DW-1:0] p_dat   = '0;
        logic          p_last  = 1'b0;
        bit done = 0;
        for (int i = 0; i < 20; i++) push_word(DW'(8'h60 + i), (i == 15) || (i == 19));
        for (int k = 0; k < 1500 && !done; k++) begin
            bus.m_ready = (k % 3 == 0);
            step();
            n_cmp++;
            if (o_rd_en && o_empty) begin
                n_bad++;
                $display("FAIL bp_rd_en_empty rd_en=1 while empty, required 0 (cycle %0d)", k);
            end
            if (p_stall) begin
                n_cmp++;
                if (!o_vld || o_dat !== p_dat || o_last !== p_last) begin
                    n_bad++;
                    $display("FAIL bp_stable valid/data/last=%b/%h/%b required 1/%h/%b",
                             o_vld, o_dat, o_last, p_dat, p_last);
                end
            end
            p_stall = o_vld && !o_rdy;
            p_dat   = o_dat;
            p_last  = o_last;
            n_cmp++;
            if (popped - accepted > 2) begin
                n_bad++;
                $display("FAIL bp_occupancy held=%0d required <=2", popped - accepted);
            end
            if (o_beat) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp unexpected beat data=%h required none", o_dat);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_last, o_dat} !== e) begin
                        n_bad++;
                        $display("FAIL bp beat last/data=%b/%h required %b/%h",
                                 o_last, o_dat, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (exp_q.size() == 0 && !o_busy) done = 1;
        end
        bus.m_ready = 1'b1;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL bp_drain pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_throughput();
        logic [DW:0] e;
        int idx = 0;
        int cyc = 0;
        int prev = 0;
        bit done = 0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 32; i++) push_word(DW'(8'h80 + i), (i == 15) || (i == 31));
        for (int k = 0; k < 1000 && !done; k++) begin
            step();
            cyc++;
            if (o_beat) begin
                if (idx % BL != 0) begin
                    n_cmp++;
                    if (cyc - prev != 1) begin
                        n_bad++;
                        $display("FAIL throughput gap=%0d before beat %0d required 1", cyc - prev, idx);
                    end
                end
                prev = cyc;
                idx++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL throughput unexpected beat data=%h required none", o_dat);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_last, o_dat} !== e) begin
                        n_bad++;
                        $display("FAIL throughput beat last/data=%b/%h required %b/%h",
                                 o_last, o_dat, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (exp_q.size() == 0 && !o_busy) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL throughput_drain pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [DW:0] e;
        logic [15:0] exp_wc = 16'hFFFE;
        bit pending = 1;
        bit done = 0;
        bus.m_ready   = 1'b1;
        wc_load_i     = 1'b1;
        wc_load_val_i = 16'hFFFE;
        step();
        wc_load_i = 1'b0;
        push_word(8'hC0, 1'b0);
        push_word(8'hC1, 1'b0);
        push_word(8'hC2, 1'b1);
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            if (pending) begin
                n_cmp++;
                if (o_wc !== exp_wc) begin
                    n_bad++;
                    $display("FAIL wrap word_count=%h required %h", o_wc, exp_wc);
                end
                pending = 0;
            end
            if (o_beat) begin
                exp_wc  = exp_wc + 16'd1;
                pending = 1;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrap unexpected beat data=%h required none", o_dat);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_last, o_dat} !== e) begin
                        n_bad++;
                        $display("FAIL wrap beat last/data=%b/%h required %b/%h",
                                 o_last, o_dat, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (exp_q.size() == 0 && !o_busy && !pending) done = 1;
        end
        n_cmp++;
        if (!done || exp_wc !== 16'h0001) begin
            n_bad++;
            $display("FAIL wrap_drain done=%b final expected wc=%h required done and 0001", done, exp_wc);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_backpressure();
        test_throughput();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
